// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-side bundle of the parametrised synchronous FIFO.
// The master modport belongs to the block driving requests; the slave modport belongs to the FIFO itself.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr, rd, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr, rd, data_in,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with a registered read port, an occupancy count and sticky error flags.
// Requests are accepted against the registered full/empty flags, so simultaneous read and write is always well defined.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_param_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              full, empty;
  logic              wr_acc, rd_acc;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr & ~full;
  assign rd_acc = bus.rd & ~empty;

  // NOTE: every signal gets its default first so no path through this block leaves one unassigned and infers a latch.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q | (bus.wr & full);
    udf_d   = udf_q | (bus.rd & empty);
    if (wr_acc) wptr_d = wptr_q + PTR_W'(1);
    if (rd_acc) begin
      rptr_d = rptr_q + PTR_W'(1);
      dout_d = mem_q[rptr_q];
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are unreadable until written, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wptr_q] <= bus.data_in;
  end

  assign bus.data_out     = dout_q;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO, next generation of the team's 16x8 FIFO. Width, depth and almost-full/almost-empty thresholds are configurable. Adds concurrent read and write in one cycle, an occupancy count output, and sticky overflow/underflow error flags. It sits between a producer and a consumer in a single clock domain, used by the verification environment's DUT wrappers and by datapath buffering.

## Interface
- DATA_W, default 8: data width in bits, ≥1.
- DEPTH, default 16: number of entries. Must be a power of two and ≥2.
- AF_LEVEL, default DEPTH-2: almost_full asserts when count ≥ AF_LEVEL. Range 1..DEPTH.
- AE_LEVEL, default 2: almost_empty asserts when count ≤ AE_LEVEL. Range 0..DEPTH-1.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr  in  1  write request.
- data_in  in  DATA_W  write data, sampled when a write is accepted.
- rd  in  1  read request.
- data_out  out  DATA_W  read data. Registered; updated only on an accepted read.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Storage: DEPTH x DATA_W array. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is held in a separate count register.
- Acceptance uses registered flags only:
  - wr_acc = wr & !full
  - rd_acc = rd & !empty
- wr_acc: mem[wptr] <= data_in; wptr increments.
- rd_acc: data_out <= mem[rptr]; rptr increments.
- count update:
  - wr_acc only: count+1
  - rd_acc only: count-1
  - both or neither: count unchanged
- Simultaneous wr & rd:
  - Neither full nor empty: both accepted; count unchanged.
  - Full: read accepted, write rejected, overflow set; count becomes DEPTH-1.
  - Empty: write accepted, read rejected, underflow set; count becomes 1. data_out does not show the new word that cycle.
- Rejected write: memory and wptr unchanged.
- Rejected read: data_out holds its previous value.
- overflow sets on the edge where wr & full. underflow sets on the edge where rd & empty. Both are cleared only by rst.
- No state machine beyond pointers and count. Behaviour is fully defined by the rules above.
- Reset (rst=1 at an edge) wins over everything. wptr, rptr, count, overflow, underflow and data_out go to 0. Memory contents are not cleared and are don't-care. Any operation presented in the reset cycle is discarded, including when reset arrives mid-stream.

## Timing
- All outputs reflect state after the most recent clock edge.
- Flags are combinational decodes of the count register: no combinational path from wr/rd to any output.
- Reset values: data_out=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), overflow=0, underflow=0.
- Write latency: a word written at edge N is readable (empty=0) after edge N. An rd at edge N+1 presents it on data_out after edge N+1.
- Read latency: one cycle from the accepting edge to data_out.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Reset then idle, DATA_W=8, DEPTH=16 -> empty=1, full=0, count=0, data_out=0, almost_empty=1, overflow=underflow=0.
- Write 0x00..0x0F, then 17th write of 0xAA -> full=1, count=16, almost_full asserted from count=14, overflow=1. Then read 16 -> data_out 0x00..0x0F in order, 0xAA never appears, empty=1.
- Wrap-around: write 10, read 10, write 10, read 10 -> data matches in order across the pointer wrap; count returns to 0.
- Simultaneous wr & rd:
  - At count=5 for 20 cycles -> count stays 5; output stream is the input stream delayed by 5 words.
  - At full -> count becomes 15, overflow=1.
  - At empty -> count becomes 1, underflow=1, data_out unchanged.
- Read while empty (rd=1, 3 cycles) -> data_out holds, count=0, underflow=1 and stays set until rst.
- Reset mid-stream: count=7, assert rst for one cycle with wr=rd=1 -> count=0, empty=1, flags cleared. The next write/read pair returns the newly written word.
